draw_scheduler: RTL

- Sequences all framebuffer writes for the game screen.
- Arbitrates round-robin between NUM_REQ sprite/line draw requesters (missiles, explosions, cities, cursor) that share one draw engine.
- Owns a full-screen background clear sweep and the final mux onto the framebuffer write port, so the draw engine and the clear never collide.

---
 rtl/draw_scheduler.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/draw_scheduler.sv
// Framebuffer write sequencer: round-robin arbitration of draw requesters onto a
// single draw engine, plus a full-screen background clear sweep and the write mux.
module draw_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned FB_SIZE  = 307200,
  parameter logic [2:0]  BG_COLOR = 3'b000,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [19*NUM_REQ-1:0]   req_addr,
  input  logic [3*NUM_REQ-1:0]    req_color,
  output logic [NUM_REQ-1:0]      grant,
  input  logic                    clear_req,
  output logic                    clear_done,
  output logic                    eng_start,
  output logic [18:0]             eng_addr,
  output logic [2:0]              eng_color,
  input  logic                    eng_finished,
  input  logic [18:0]             eng_waddr,
  input  logic [2:0]              eng_wdata,
  input  logic                    eng_wenable,
  output logic [18:0]             mem_waddr,
  output logic [2:0]              mem_wdata,
  output logic                    mem_wenable,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned ADDR_W  = 19;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned TCNT_W  = 16;
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST  = TCNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0]  RR_INIT   = PTR_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT_LO,
    WAIT_HI
  } state_t;

  state_t              state, state_nx;
  logic [PTR_W-1:0]    rr, rr_nx;
  logic                pend, pend_nx;
  logic [ADDR_W-1:0]   sweep, sweep_nx;
  logic [TCNT_W-1:0]   tcnt, tcnt_nx;

  logic [NUM_REQ-1:0]  grant_nx;
  logic                clear_done_nx;
  logic                eng_start_nx;
  logic [ADDR_W-1:0]   eng_addr_nx;
  logic [COLOR_W-1:0]  eng_color_nx;
  logic                busy_nx;
  logic                err_nx;

  int unsigned         base;
  logic [NUM_REQ-1:0]  req_rot;
  logic                found;
  logic [PTR_W-1:0]    win;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [ADDR_W-1:0]   win_addr;
  logic [COLOR_W-1:0]  win_color;

  // Rotate requests so bit 0 is the requester just after the last winner, then pick the lowest.
  always_comb begin
    base    = 32'(rr) + 32'd1;
    req_rot = NUM_REQ'({req, req} >> base);
    found   = 1'b0;
    win     = rr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        win   = PTR_W'((base + k) % NUM_REQ);
      end
    end
  end

  // Winner's operand slices and one-hot grant vector.
  always_comb begin
    win_onehot = '0;
    win_addr   = '0;
    win_color  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_onehot[i] = 1'b1;
        win_addr      = req_addr[i*ADDR_W +: ADDR_W];
        win_color     = req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx     = state;
    rr_nx        = rr;
    pend_nx      = pend | clear_req;
    sweep_nx     = sweep;
    tcnt_nx      = tcnt;
    grant_nx     = '0;
    eng_addr_nx  = eng_addr;
    eng_color_nx = eng_color;
    err_nx       = err;

    case (state)
      IDLE: begin
        if (pend || clear_req) begin
          state_nx = CLEAR;
          pend_nx  = 1'b0;
        end else if (found) begin
          state_nx     = START;
          rr_nx        = win;
          grant_nx     = win_onehot;
          eng_addr_nx  = win_addr;
          eng_color_nx = win_color;
        end
      end
      CLEAR: begin
        if (sweep == LAST_ADDR) begin
          sweep_nx = '0;
          state_nx = IDLE;
        end else begin
          sweep_nx = sweep + 19'd1;
        end
      end
      START: begin
        state_nx = WAIT_LO;
        tcnt_nx  = '0;
      end
      WAIT_LO, WAIT_HI: begin
        tcnt_nx = tcnt + 16'd1;
        // A completion on the final allowed cycle still counts as a completion.
        if (state == WAIT_HI && eng_finished) begin
          state_nx = IDLE;
        end else if (tcnt == TMO_LAST) begin
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else if (state == WAIT_LO && !eng_finished) begin
          state_nx = WAIT_HI;
        end
      end
      default: state_nx = IDLE;
    endcase

    eng_start_nx  = (state == START);
    busy_nx       = (state_nx != IDLE);
    // Registered, so look one cycle ahead to line up with the last sweep write.
    clear_done_nx = (state_nx == CLEAR) && (sweep_nx == LAST_ADDR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= RR_INIT;
      pend       <= 1'b0;
      sweep      <= '0;
      tcnt       <= '0;
      grant      <= '0;
      clear_done <= 1'b0;
      eng_start  <= 1'b0;
      eng_addr   <= '0;
      eng_color  <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      rr         <= rr_nx;
      pend       <= pend_nx;
      sweep      <= sweep_nx;
      tcnt       <= tcnt_nx;
      grant      <= grant_nx;
      clear_done <= clear_done_nx;
      eng_start  <= eng_start_nx;
      eng_addr   <= eng_addr_nx;
      eng_color  <= eng_color_nx;
      busy       <= busy_nx;
      err        <= err_nx;
    end
  end

  // Framebuffer port: sweep owns it in CLEAR, engine only while a draw is in flight.
  always_comb begin
    mem_waddr   = eng_waddr;
    mem_wdata   = eng_wdata;
    mem_wenable = 1'b0;
    case (state)
      CLEAR: begin
        mem_waddr   = sweep;
        mem_wdata   = BG_COLOR;
        mem_wenable = 1'b1;
      end
      WAIT_LO, WAIT_HI: mem_wenable = eng_wenable;
      default: ;
    endcase
  end

endmodule
